if_line_buffer: RTL and testbench

//  Instruction-fetch line buffer between the CPU IF stage and the cache_memory instruction port.

---
 rtl/if_line_buffer.sv | 150 +++++++++++++++
 tb/tb_if_line_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_line_buffer.sv
// Instruction-fetch line buffer: serves 32-bit fetches from one cached 128-bit line and refills it on a miss.
// Hit latency 1 cycle, miss latency 1 cycle after rom_done; a flushed read is drained but never delivered.
module if_line_buffer #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_req_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              inv_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              rom_read_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [LINE_W-1:0] rom_data_i,
    input  logic              rom_done_i
);
    localparam int TAG_W = ADDR_W - 4;

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t            state, state_nxt;
    logic              line_valid, line_valid_nxt;
    logic              no_fill, no_fill_nxt;
    logic [TAG_W-1:0]  line_tag, line_tag_nxt;
    logic [LINE_W-1:0] line_data, line_data_nxt;
    logic [ADDR_W-1:0] pend_pc, pend_pc_nxt;
    logic              rom_read_nxt;
    logic [ADDR_W-1:0] rom_addr_nxt;
    logic              inst_valid_nxt;
    logic [INST_W-1:0] inst_nxt;
    logic [ADDR_W-1:0] inst_pc_nxt;
    logic              hit;

    function automatic logic [INST_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0] idx);
        logic [INST_W-1:0] w;
        case (idx)
            2'd0:    w = line[0*INST_W +: INST_W];
            2'd1:    w = line[1*INST_W +: INST_W];
            2'd2:    w = line[2*INST_W +: INST_W];
            default: w = line[3*INST_W +: INST_W];
        endcase
        return w;
    endfunction

    // A same-cycle fence.i turns a would-be hit into a miss.
    assign hit = line_valid && (line_tag == pc_i[ADDR_W-1:4]) && !inv_i;

    always_comb begin
        state_nxt      = state;
        line_valid_nxt = line_valid;
        no_fill_nxt    = no_fill;
        line_tag_nxt   = line_tag;
        line_data_nxt  = line_data;
        pend_pc_nxt    = pend_pc;
        rom_read_nxt   = rom_read_o;
        rom_addr_nxt   = rom_addr_o;
        inst_valid_nxt = 1'b0;
        inst_nxt       = inst_o;
        inst_pc_nxt    = inst_pc_o;

        if (inv_i) begin
            line_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                no_fill_nxt = 1'b0;
                if (pc_req_i && !flush_i) begin
                    if (hit) begin
                        inst_valid_nxt = 1'b1;
                        inst_nxt       = sel_word(line_data, pc_i[3:2]);
                        inst_pc_nxt    = pc_i;
                    end else begin
                        pend_pc_nxt  = pc_i;
                        rom_read_nxt = 1'b1;
                        rom_addr_nxt = {pc_i[ADDR_W-1:4], 4'b0000};
                        state_nxt    = FETCH;
                    end
                end
            end
            FETCH, DISCARD: begin
                if (rom_done_i) begin
                    rom_read_nxt = 1'b0;
                    if (!no_fill && !inv_i) begin
                        line_valid_nxt = 1'b1;
                        line_tag_nxt   = pend_pc[ADDR_W-1:4];
                        line_data_nxt  = rom_data_i;
                    end
                    if (state == FETCH && !flush_i) begin
                        inst_valid_nxt = 1'b1;
                        inst_nxt       = sel_word(rom_data_i, pend_pc[3:2]);
                        inst_pc_nxt    = pend_pc;
                    end
                    no_fill_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    if (inv_i) begin
                        no_fill_nxt = 1'b1;
                    end
                    // The cache cannot abort, so a redirect only marks the read as unwanted.
                    if (state == FETCH && flush_i) begin
                        state_nxt = DISCARD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid   <= 1'b0;
            no_fill      <= 1'b0;
            line_tag     <= '0;
            line_data    <= '0;
            pend_pc      <= '0;
            rom_read_o   <= 1'b0;
            rom_addr_o   <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
        end else begin
            line_valid   <= line_valid_nxt;
            no_fill      <= no_fill_nxt;
            line_tag     <= line_tag_nxt;
            line_data    <= line_data_nxt;
            pend_pc      <= pend_pc_nxt;
            rom_read_o   <= rom_read_nxt;
            rom_addr_o   <= rom_addr_nxt;
            inst_valid_o <= inst_valid_nxt;
            inst_o       <= inst_nxt;
            inst_pc_o    <= inst_pc_nxt;
        end
    end

endmodule

// File: tb/tb_if_line_buffer.sv
// Bench for if_line_buffer: directed vector table, reset-mid-fetch sequence, then random traffic vs a reference model.
module tb_if_line_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pc_req_i = 1'b0;
    logic [31:0]  pc_i = '0;
    logic         flush_i = 1'b0;
    logic         inv_i = 1'b0;
    logic         inst_valid_o;
    logic [31:0]  inst_o;
    logic [31:0]  inst_pc_o;
    logic         rom_read_o;
    logic [31:0]  rom_addr_o;
    logic [127:0] rom_data_i = '0;
    logic         rom_done_i = 1'b0;

    int nchk = 0;
    int nerr = 0;

    if_line_buffer dut (
        .clk(clk), .rst(rst), .pc_req_i(pc_req_i), .pc_i(pc_i), .flush_i(flush_i), .inv_i(inv_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .rom_read_o(rom_read_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .rom_done_i(rom_done_i)
    );

    always #5 clk = ~clk;

    // Memory content: each word address has a distinct pseudo-random value.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'hFFFF_FFF0;
        return {mem_word(b + 12), mem_word(b + 8), mem_word(b + 4), mem_word(b)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        flush;
        logic        inv;
        logic        done;
        logic [31:0] ln;
        logic        rd;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] inst;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic req, input logic [31:0] pc, input logic flush, input logic inv,
                        input logic done, input logic [31:0] ln, input logic rd, input logic [31:0] addr,
                        input logic iv, input logic [31:0] ipc);
        vec_t v;
        v.req = req; v.pc = pc; v.flush = flush; v.inv = inv; v.done = done; v.ln = ln;
        v.rd = rd; v.addr = addr; v.iv = iv; v.ipc = ipc; v.inst = mem_word(ipc);
        vt.push_back(v);
    endtask

    // Reference model: one outstanding line read, one cached line, plus flags for a
    // read whose result must not be delivered (drop) or must not be cached (stale).
    logic        m_busy, m_drop, m_stale, m_have;
    logic [31:0] m_line, m_pend;
    logic        e_rd, e_iv;
    logic [31:0] e_addr, e_inst, e_ipc;

    task automatic model_reset();
        m_busy = 0; m_drop = 0; m_stale = 0; m_have = 0; m_line = '0; m_pend = '0;
        e_rd = 0; e_iv = 0; e_addr = '0; e_inst = '0; e_ipc = '0;
    endtask

    task automatic model_cycle(input logic req, input logic [31:0] pc, input logic flush,
                               input logic inv, input logic done);
        logic was_have;
        was_have = m_have;
        e_iv = 0;
        if (inv) m_have = 0;
        if (!m_busy) begin
            if (req && !flush) begin
                if (was_have && !inv && (m_line == (pc & 32'hFFFF_FFF0))) begin
                    e_iv = 1; e_ipc = pc; e_inst = mem_word(pc);
                end else begin
                    m_busy = 1; m_drop = 0; m_stale = 0; m_pend = pc;
                    e_rd = 1; e_addr = pc & 32'hFFFF_FFF0;
                end
            end
        end else if (done) begin
            e_rd = 0;
            if (!m_stale && !inv) begin
                m_have = 1; m_line = m_pend & 32'hFFFF_FFF0;
            end
            if (!m_drop && !flush) begin
                e_iv = 1; e_ipc = m_pend; e_inst = mem_word(m_pend);
            end
            m_busy = 0;
        end else begin
            if (flush) m_drop = 1;
            if (inv) m_stale = 1;
        end
    endtask

    logic [31:0] bases [4] = '{32'h0000_1000, 32'h0000_1010, 32'h0000_2000, 32'hFFFF_FFF0};

    initial begin
        logic        hold;
        logic [31:0] hpc;
        logic        rsp_active;
        int          rsp_cnt;

        // Reset state
        step();
        chk("rst_rd", {31'b0, rom_read_o}, 32'd0);
        chk("rst_addr", rom_addr_o, 32'd0);
        chk("rst_iv", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_ipc", inst_pc_o, 32'd0);
        rst = 1'b0;
        step();

        // Directed vectors: inputs applied, one edge, outputs compared
        addv(1, 32'h100, 0, 0, 0, 0,             1, 32'h100, 0, 0);
        addv(1, 32'h100, 0, 0, 0, 0,             1, 32'h100, 0, 0);
        addv(1, 32'h100, 0, 0, 1, 32'h100,       0, 0,       1, 32'h100);
        addv(1, 32'h108, 0, 0, 0, 0,             0, 0,       1, 32'h108);
        addv(1, 32'h10C, 0, 0, 0, 0,             0, 0,       1, 32'h10C);
        addv(1, 32'h200, 0, 0, 0, 0,             1, 32'h200, 0, 0);
        addv(0, 32'h0,   0, 0, 0, 0,             1, 32'h200, 0, 0);
        addv(0, 32'h0,   1, 0, 0, 0,             1, 32'h200, 0, 0);
        addv(0, 32'h0,   0, 0, 0, 0,             1, 32'h200, 0, 0);
        addv(0, 32'h0,   0, 0, 1, 32'h200,       0, 0,       0, 0);
        addv(1, 32'h204, 0, 0, 0, 0,             0, 0,       1, 32'h204);
        addv(1, 32'h300, 0, 0, 0, 0,             1, 32'h300, 0, 0);
        addv(1, 32'h300, 1, 0, 1, 32'h300,       0, 0,       0, 0);
        addv(1, 32'h300, 0, 0, 0, 0,             0, 0,       1, 32'h300);
        addv(1, 32'h400, 0, 0, 0, 0,             1, 32'h400, 0, 0);
        addv(1, 32'h400, 0, 1, 0, 0,             1, 32'h400, 0, 0);
        addv(1, 32'h400, 0, 0, 1, 32'h400,       0, 0,       1, 32'h400);
        addv(1, 32'h404, 0, 0, 0, 0,             1, 32'h400, 0, 0);
        addv(1, 32'h404, 0, 0, 1, 32'h400,       0, 0,       1, 32'h404);
        addv(1, 32'h408, 0, 1, 0, 0,             1, 32'h400, 0, 0);
        addv(1, 32'h408, 0, 0, 1, 32'h400,       0, 0,       1, 32'h408);
        addv(1, 32'h40C, 1, 0, 0, 0,             0, 0,       0, 0);
        addv(1, 32'hFFFF_FFFC, 0, 0, 0, 0,       1, 32'hFFFF_FFF0, 0, 0);
        addv(1, 32'hFFFF_FFFC, 0, 0, 1, 32'hFFFF_FFF0, 0, 0, 1, 32'hFFFF_FFFC);
        addv(0, 32'h0,   0, 0, 1, 32'h0,         0, 0,       0, 0);
        addv(1, 32'hFFFF_FFF8, 0, 0, 0, 0,       0, 0,       1, 32'hFFFF_FFF8);

        foreach (vt[i]) begin
            pc_req_i = vt[i].req; pc_i = vt[i].pc; flush_i = vt[i].flush; inv_i = vt[i].inv;
            rom_done_i = vt[i].done; rom_data_i = line_of(vt[i].ln);
            step();
            chk($sformatf("vec%0d_rd", i), {31'b0, rom_read_o}, {31'b0, vt[i].rd});
            if (vt[i].rd) chk($sformatf("vec%0d_addr", i), rom_addr_o, vt[i].addr);
            chk($sformatf("vec%0d_iv", i), {31'b0, inst_valid_o}, {31'b0, vt[i].iv});
            if (vt[i].iv) begin
                chk($sformatf("vec%0d_inst", i), inst_o, vt[i].inst);
                chk($sformatf("vec%0d_ipc", i), inst_pc_o, vt[i].ipc);
            end
        end
        pc_req_i = 0; flush_i = 0; inv_i = 0; rom_done_i = 0;

        // Reset in the middle of a fetch
        pc_req_i = 1; pc_i = 32'h500;
        step();
        chk("t6_rd", {31'b0, rom_read_o}, 32'd1);
        chk("t6_addr", rom_addr_o, 32'h500);
        pc_req_i = 0;
        step();
        rst = 1'b1;
        #1;
        chk("t6_rst_rd", {31'b0, rom_read_o}, 32'd0);
        step();
        rst = 1'b0;
        rom_done_i = 1; rom_data_i = line_of(32'h500);
        step();
        chk("t6_stray_rd", {31'b0, rom_read_o}, 32'd0);
        chk("t6_stray_iv", {31'b0, inst_valid_o}, 32'd0);
        rom_done_i = 0; pc_req_i = 1; pc_i = 32'h100;
        step();
        chk("t6_miss_rd", {31'b0, rom_read_o}, 32'd1);
        chk("t6_miss_addr", rom_addr_o, 32'h100);
        rom_done_i = 1; rom_data_i = line_of(32'h100);
        step();
        chk("t6_iv", {31'b0, inst_valid_o}, 32'd1);
        chk("t6_inst", inst_o, mem_word(32'h100));
        chk("t6_ipc", inst_pc_o, 32'h100);
        pc_req_i = 0; rom_done_i = 0;

        // Random traffic against the reference model
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        hold = 0; hpc = '0; rsp_active = 0; rsp_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_rd", {31'b0, rom_read_o}, {31'b0, e_rd});
            if (e_rd) chk("rnd_addr", rom_addr_o, e_addr);
            chk("rnd_iv", {31'b0, inst_valid_o}, {31'b0, e_iv});
            if (e_iv) begin
                chk("rnd_inst", inst_o, e_inst);
                chk("rnd_ipc", inst_pc_o, e_ipc);
            end

            rom_done_i = 0;
            if (rom_read_o && !rsp_active) begin
                rsp_active = 1;
                rsp_cnt = $urandom_range(0, 3);
            end
            if (rsp_active) begin
                if (rsp_cnt == 0) begin
                    rom_done_i = 1; rom_data_i = line_of(rom_addr_o); rsp_active = 0;
                end else begin
                    rsp_cnt--;
                end
            end else if (($urandom % 25) == 0) begin
                rom_done_i = 1; rom_data_i = {$urandom, $urandom, $urandom, $urandom};
            end

            if (e_iv) hold = 0;
            if (!hold && ($urandom % 3) != 0) begin
                hold = 1;
                hpc = bases[$urandom % 4] + 32'(($urandom % 4) * 4);
            end
            flush_i = (($urandom % 16) == 0);
            inv_i = (($urandom % 20) == 0);
            pc_req_i = hold;
            pc_i = hold ? hpc : $urandom;
            model_cycle(pc_req_i, pc_i, flush_i, inv_i, rom_done_i);
            if (flush_i) hold = 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
